// File: rtl/hv_generator_mux.sv
// hv_generator_mux: streams one (item-memory, projection) fold pair per channel per fold for GSR/ECG/EEG.
// Optional macro HVGEN_DOUBLE_BUFFER_EN adds a one-entry shadow sample buffer for gapless back-to-back samples.
module hv_generator_mux #(
  parameter int HV_DIMENSION          = 2000,
  parameter int NUM_FOLDS             = 1,
  parameter int NUM_FOLDS_WIDTH       = 1,
  parameter int FOLD_WIDTH            = 2000,
  parameter int CHANNEL_WIDTH         = 2,
  parameter int GSR_NUM_CHANNEL       = 32,
  parameter int ECG_NUM_CHANNEL       = 77,
  parameter int EEG_NUM_CHANNEL       = 105,
  parameter int MAX_NUM_CHANNEL_WIDTH = 7,
  parameter logic [HV_DIMENSION-1:0] SEED_HV = HV_DIMENSION'(64'h9E37_79B9_7F4A_7C15),
  localparam int TOTAL_W = (GSR_NUM_CHANNEL + ECG_NUM_CHANNEL + EEG_NUM_CHANNEL > 0) ?
                           (GSR_NUM_CHANNEL + ECG_NUM_CHANNEL + EEG_NUM_CHANNEL) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fin_valid,
  output logic                             fin_ready,
  input  logic [CHANNEL_WIDTH*TOTAL_W-1:0] features,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [FOLD_WIDTH-1:0]            im_out,
  output logic [FOLD_WIDTH-1:0]            projm_out,
  output logic [1:0]                       dout_modality,
  output logic [NUM_FOLDS_WIDTH-1:0]       dout_fold,
  output logic [MAX_NUM_CHANNEL_WIDTH-1:0] dout_channel,
  output logic                             dout_last_channel,
  output logic                             dout_last
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GSR = 2'd1, S_ECG = 2'd2, S_EEG = 2'd3} state_t;

  localparam int ECG_BASE = GSR_NUM_CHANNEL;
  localparam int EEG_BASE = GSR_NUM_CHANNEL + ECG_NUM_CHANNEL;
  localparam logic [HV_DIMENSION-1:0] P_POS    = SEED_HV;
  localparam logic [HV_DIMENSION-1:0] P_NEG    = (P_POS << 1) ^ (P_POS >> 1);
  localparam logic [HV_DIMENSION-1:0] IM_START = (P_NEG << 1) ^ (P_NEG >> 1);

  state_t                             r_state, w_state_next;
  logic [NUM_FOLDS_WIDTH-1:0]         r_fold, w_fold_next;
  logic [MAX_NUM_CHANNEL_WIDTH-1:0]   r_chan, w_chan_next;
  logic [HV_DIMENSION-1:0]            r_im, w_im_next;
  logic [CHANNEL_WIDTH*TOTAL_W-1:0]   r_feat, w_feat_next;
`ifdef HVGEN_DOUBLE_BUFFER_EN
  logic [CHANNEL_WIDTH*TOTAL_W-1:0]   r_shadow, w_shadow_next;
  logic                               r_shadow_full, w_shadow_full_next;
`endif

  state_t w_first, w_after;
  logic   w_fire, w_accept, w_last_chan, w_last_fold, w_sample_end;
  logic [CHANNEL_WIDTH-1:0] w_code;

  // Fold slices are picked by OR-ing masked candidates so no variable part-select is needed.
  logic [FOLD_WIDTH-1:0] w_im_acc  [NUM_FOLDS+1];
  logic [FOLD_WIDTH-1:0] w_pos_acc [NUM_FOLDS+1];
  logic [FOLD_WIDTH-1:0] w_neg_acc [NUM_FOLDS+1];
  logic [CHANNEL_WIDTH-1:0] w_code_acc [TOTAL_W+1];

  assign w_im_acc[0]   = '0;
  assign w_pos_acc[0]  = '0;
  assign w_neg_acc[0]  = '0;
  assign w_code_acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FOLDS; gi++) begin : g_fold
      logic w_hit;
      assign w_hit = (r_fold == NUM_FOLDS_WIDTH'(gi));
      assign w_im_acc[gi+1]  = w_im_acc[gi]  | (w_hit ? r_im[gi*FOLD_WIDTH +: FOLD_WIDTH]  : '0);
      assign w_pos_acc[gi+1] = w_pos_acc[gi] | (w_hit ? P_POS[gi*FOLD_WIDTH +: FOLD_WIDTH] : '0);
      assign w_neg_acc[gi+1] = w_neg_acc[gi] | (w_hit ? P_NEG[gi*FOLD_WIDTH +: FOLD_WIDTH] : '0);
    end
    for (gi = 0; gi < TOTAL_W; gi++) begin : g_code
      logic w_hit;
      if (gi < ECG_BASE) begin : g_gsr
        assign w_hit = (r_state == S_GSR) && (r_chan == MAX_NUM_CHANNEL_WIDTH'(gi));
      end else if (gi < EEG_BASE) begin : g_ecg
        assign w_hit = (r_state == S_ECG) && (r_chan == MAX_NUM_CHANNEL_WIDTH'(gi - ECG_BASE));
      end else begin : g_eeg
        assign w_hit = (r_state == S_EEG) && (r_chan == MAX_NUM_CHANNEL_WIDTH'(gi - EEG_BASE));
      end
      assign w_code_acc[gi+1] = w_code_acc[gi] |
                                (w_hit ? r_feat[gi*CHANNEL_WIDTH +: CHANNEL_WIDTH] : '0);
    end
  endgenerate

  assign w_code     = w_code_acc[TOTAL_W];
  assign dout_valid = (r_state != S_IDLE);
`ifdef HVGEN_DOUBLE_BUFFER_EN
  assign fin_ready  = !r_shadow_full;
`else
  assign fin_ready  = (r_state == S_IDLE);
`endif
  assign w_fire      = dout_valid && dout_ready;
  assign w_accept    = fin_valid && fin_ready;
  assign w_last_fold = (r_fold == NUM_FOLDS_WIDTH'(NUM_FOLDS - 1));

  always_comb begin
    w_first = S_IDLE;
    if (GSR_NUM_CHANNEL > 0)      w_first = S_GSR;
    else if (ECG_NUM_CHANNEL > 0) w_first = S_ECG;
    else if (EEG_NUM_CHANNEL > 0) w_first = S_EEG;
    w_after     = S_IDLE;
    w_last_chan = 1'b0;
    case (r_state)
      S_GSR: begin
        w_last_chan = (r_chan == MAX_NUM_CHANNEL_WIDTH'(GSR_NUM_CHANNEL - 1));
        if (ECG_NUM_CHANNEL > 0)      w_after = S_ECG;
        else if (EEG_NUM_CHANNEL > 0) w_after = S_EEG;
      end
      S_ECG: begin
        w_last_chan = (r_chan == MAX_NUM_CHANNEL_WIDTH'(ECG_NUM_CHANNEL - 1));
        if (EEG_NUM_CHANNEL > 0) w_after = S_EEG;
      end
      S_EEG:   w_last_chan = (r_chan == MAX_NUM_CHANNEL_WIDTH'(EEG_NUM_CHANNEL - 1));
      default: w_last_chan = 1'b0;
    endcase
    w_sample_end = w_last_chan && w_last_fold && (w_after == S_IDLE);
  end

  always_comb begin
    w_state_next = r_state;
    w_fold_next  = r_fold;
    w_chan_next  = r_chan;
    w_im_next    = r_im;
    w_feat_next  = r_feat;
`ifdef HVGEN_DOUBLE_BUFFER_EN
    w_shadow_next      = r_shadow;
    w_shadow_full_next = r_shadow_full;
`endif
    if (w_fire) begin
      if (!w_last_chan) begin
        w_chan_next = r_chan + MAX_NUM_CHANNEL_WIDTH'(1);
        w_im_next   = (r_im << 1) ^ (r_im >> 1);
      end else begin
        w_chan_next = '0;
        w_im_next   = IM_START;
        if (!w_last_fold) begin
          w_fold_next = r_fold + NUM_FOLDS_WIDTH'(1);
        end else begin
          w_fold_next  = '0;
          w_state_next = w_after;
        end
      end
    end
`ifdef HVGEN_DOUBLE_BUFFER_EN
    if (w_fire && w_sample_end) begin
      if (r_shadow_full) begin
        w_feat_next        = r_shadow;
        w_shadow_full_next = 1'b0;
        w_state_next       = w_first;
      end else if (w_accept) begin
        w_feat_next  = features;
        w_state_next = w_first;
      end
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        w_feat_next  = features;
        w_state_next = w_first;
        w_im_next    = IM_START;
      end else begin
        w_shadow_next      = features;
        w_shadow_full_next = 1'b1;
      end
    end
`else
    if (w_accept) begin
      w_feat_next  = features;
      w_state_next = w_first;
      w_im_next    = IM_START;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fold  <= '0;
      r_chan  <= '0;
      r_im    <= '0;
      r_feat  <= '0;
`ifdef HVGEN_DOUBLE_BUFFER_EN
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_fold  <= w_fold_next;
      r_chan  <= w_chan_next;
      r_im    <= w_im_next;
      r_feat  <= w_feat_next;
`ifdef HVGEN_DOUBLE_BUFFER_EN
      r_shadow      <= w_shadow_next;
      r_shadow_full <= w_shadow_full_next;
`endif
    end
  end

  always_comb begin
    dout_modality = 2'd0;
    case (r_state)
      S_ECG:   dout_modality = 2'd1;
      S_EEG:   dout_modality = 2'd2;
      default: dout_modality = 2'd0;
    endcase
  end

  assign im_out            = dout_valid ? w_im_acc[NUM_FOLDS] : '0;
  assign projm_out         = !dout_valid                      ? '0 :
                             (w_code == CHANNEL_WIDTH'(1))    ? w_pos_acc[NUM_FOLDS] :
                             (w_code == CHANNEL_WIDTH'(2))    ? w_neg_acc[NUM_FOLDS] : '0;
  assign dout_fold         = r_fold;
  assign dout_channel      = r_chan;
  assign dout_last_channel = dout_valid && w_last_chan;
  assign dout_last         = dout_valid && w_sample_end;

endmodule

// File: tb/tb_hv_generator_mux.sv
// Directed bench for hv_generator_mux: 8-bit HV, 2 folds of 4 bits, channels 2/1/3 plus a 2/0/3 instance.
module tb_hv_generator_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fin_valid, fin_ready, dout_valid, dout_ready;
  logic [11:0] features;
  logic [3:0]  im_out, projm_out;
  logic [1:0]  dout_modality, dout_channel;
  logic [0:0]  dout_fold;
  logic        dout_last_channel, dout_last;

  logic        z_fin_valid, z_fin_ready, z_dout_valid, z_dout_ready;
  logic [9:0]  z_features;
  logic [3:0]  z_im_out, z_projm_out;
  logic [1:0]  z_dout_modality, z_dout_channel;
  logic [0:0]  z_dout_fold;
  logic        z_dout_last_channel, z_dout_last;

  int checks = 0;
  int errors = 0;

  hv_generator_mux #(
    .HV_DIMENSION(8), .NUM_FOLDS(2), .NUM_FOLDS_WIDTH(1), .FOLD_WIDTH(4), .CHANNEL_WIDTH(2),
    .GSR_NUM_CHANNEL(2), .ECG_NUM_CHANNEL(1), .EEG_NUM_CHANNEL(3),
    .MAX_NUM_CHANNEL_WIDTH(2), .SEED_HV(8'h01)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fin_valid(fin_valid), .fin_ready(fin_ready), .features(features),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .im_out(im_out), .projm_out(projm_out),
    .dout_modality(dout_modality), .dout_fold(dout_fold), .dout_channel(dout_channel),
    .dout_last_channel(dout_last_channel), .dout_last(dout_last)
  );

  hv_generator_mux #(
    .HV_DIMENSION(8), .NUM_FOLDS(2), .NUM_FOLDS_WIDTH(1), .FOLD_WIDTH(4), .CHANNEL_WIDTH(2),
    .GSR_NUM_CHANNEL(2), .ECG_NUM_CHANNEL(0), .EEG_NUM_CHANNEL(3),
    .MAX_NUM_CHANNEL_WIDTH(2), .SEED_HV(8'h01)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .fin_valid(z_fin_valid), .fin_ready(z_fin_ready), .features(z_features),
    .dout_valid(z_dout_valid), .dout_ready(z_dout_ready), .im_out(z_im_out), .projm_out(z_projm_out),
    .dout_modality(z_dout_modality), .dout_fold(z_dout_fold), .dout_channel(z_dout_channel),
    .dout_last_channel(z_dout_last_channel), .dout_last(z_dout_last)
  );

  // Hand-derived beat table for channels 2/1/3; IM folds follow R^(c+1)(8'h02).
  int e_mod [12] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 2, 2};
  int e_fold[12] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1};
  int e_chan[12] = '{0, 1, 0, 1, 0, 0, 0, 1, 2, 0, 1, 2};
  int e_im  [12] = '{5, 8, 0, 0, 5, 0, 5, 8, 4, 0, 0, 1};
  int e_lc  [12] = '{0, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1};
  int e_gidx[12] = '{0, 1, 0, 1, 2, 2, 3, 4, 5, 3, 4, 5};
  int z_map [10] = '{0, 1, 2, 3, 6, 7, 8, 9, 10, 11};
  int z_gidx[10] = '{0, 1, 0, 1, 2, 3, 4, 2, 3, 4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // P+ = 8'h01, P- = 8'h02: only fold 0 carries set bits.
  function automatic int exp_projm(input logic [11:0] feat, input int g, input int fold);
    logic [1:0] code;
    code = 2'(feat >> (2 * g));
    if (fold != 0) return 0;
    if (code == 2'd1) return 1;
    if (code == 2'd2) return 2;
    return 0;
  endfunction

  task automatic send(input bit z, input logic [11:0] feat);
    int w = 0;
    if (z) begin z_features = feat[9:0]; z_fin_valid = 1'b1; end
    else   begin features = feat;        fin_valid   = 1'b1; end
    while (!(z ? z_fin_ready : fin_ready) && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("send_ready", 32'(z ? z_fin_ready : fin_ready), 32'd1);
    @(posedge clk); #1;
    fin_valid = 1'b0; z_fin_valid = 1'b0;
    check("latency_valid", 32'(z ? z_dout_valid : dout_valid), 32'd1);
  endtask

  task automatic collect(input bit z, input bit bp, input int n, input logic [11:0] feat);
    int beat = 0;
    int cyc = 0;
    int k;
    bit stalled = 1'b0;
    bit acc, v, rdy, fr;
    logic [31:0] cur_im, cur_pj, cur_meta, hold_im, hold_pj, hold_meta;
    hold_im = '0; hold_pj = '0; hold_meta = '0;
    while (beat < n && cyc < 400) begin
      v        = z ? z_dout_valid : dout_valid;
      fr       = z ? z_fin_ready : fin_ready;
      cur_im   = z ? 32'(z_im_out) : 32'(im_out);
      cur_pj   = z ? 32'(z_projm_out) : 32'(projm_out);
      cur_meta = z ? {25'd0, z_dout_modality, z_dout_fold, z_dout_channel, z_dout_last_channel, z_dout_last}
                   : {25'd0, dout_modality, dout_fold, dout_channel, dout_last_channel, dout_last};
      if (stalled) begin
        check($sformatf("stall_valid[%0d]", beat), 32'(v), 32'd1);
        check($sformatf("stall_im[%0d]", beat), cur_im, hold_im);
        check($sformatf("stall_projm[%0d]", beat), cur_pj, hold_pj);
        check($sformatf("stall_meta[%0d]", beat), cur_meta, hold_meta);
      end
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      dout_ready = rdy; z_dout_ready = rdy;
      acc = z ? (z_fin_valid && z_fin_ready) : (fin_valid && fin_ready);
      if (v) begin
`ifndef HVGEN_DOUBLE_BUFFER_EN
        check($sformatf("busy_fin_ready[%0d]", beat), 32'(fr), 32'd0);
`endif
        if (rdy) begin
          k = z ? z_map[beat] : beat;
          check($sformatf("modality[%0d]", beat), cur_meta[6:5], e_mod[k]);
          check($sformatf("fold[%0d]", beat), cur_meta[4], e_fold[k]);
          check($sformatf("channel[%0d]", beat), cur_meta[3:2], e_chan[k]);
          check($sformatf("last_channel[%0d]", beat), cur_meta[1], e_lc[k]);
          check($sformatf("last[%0d]", beat), cur_meta[0], 32'(k == 11));
          check($sformatf("im[%0d]", beat), cur_im, e_im[k]);
          check($sformatf("projm[%0d]", beat), cur_pj,
                exp_projm(feat, z ? z_gidx[beat] : e_gidx[k], e_fold[k]));
          beat++;
          stalled = 1'b0;
        end else begin
          hold_im = cur_im; hold_pj = cur_pj; hold_meta = cur_meta;
          stalled = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (z) z_fin_valid = 1'b0;
        else   fin_valid = 1'b0;
      end
    end
    check("beat_count", beat, n);
  endtask

  initial begin
    rst_n = 1'b0; fin_valid = 1'b0; z_fin_valid = 1'b0;
    dout_ready = 1'b0; z_dout_ready = 1'b0; features = '0; z_features = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_im", 32'(im_out), 32'd0);
    check("rst_projm", 32'(projm_out), 32'd0);
    check("rst_meta", {25'd0, dout_modality, dout_fold, dout_channel, dout_last_channel, dout_last}, 32'd0);
    check("rst_fin_ready", 32'(fin_ready), 32'd1);
    check("rst_z_fin_ready", 32'(z_fin_ready), 32'd1);

    // Basic sequence with codes 1/2/0/3/1/2 on GSR0, GSR1, ECG0, EEG0..2.
    send(1'b0, 12'h9C9);
    collect(1'b0, 1'b0, 12, 12'h9C9);
    check("basic_end_valid", 32'(dout_valid), 32'd0);
    check("basic_end_fin_ready", 32'(fin_ready), 32'd1);

    // Random backpressure: same beats, outputs held while stalled.
    send(1'b0, 12'h9C9);
    collect(1'b0, 1'b1, 12, 12'h9C9);
    check("bp_end_valid", 32'(dout_valid), 32'd0);

    // ECG has zero channels on the second instance.
    send(1'b1, 12'h279);
    collect(1'b1, 1'b0, 10, 12'h279);
    check("zero_end_valid", 32'(z_dout_valid), 32'd0);

    // Back-to-back: second sample (all codes 1) offered during the first.
    send(1'b0, 12'h9C9);
    features = 12'h555; fin_valid = 1'b1;
    collect(1'b0, 1'b0, 12, 12'h9C9);
`ifdef HVGEN_DOUBLE_BUFFER_EN
    check("b2b_no_bubble", 32'(dout_valid), 32'd1);
`else
    check("b2b_bubble_valid", 32'(dout_valid), 32'd0);
    check("b2b_bubble_fin_ready", 32'(fin_ready), 32'd1);
    @(posedge clk); #1;
    fin_valid = 1'b0;
    check("b2b_second_valid", 32'(dout_valid), 32'd1);
`endif
    collect(1'b0, 1'b0, 12, 12'h555);
    check("b2b_end_valid", 32'(dout_valid), 32'd0);

    // Reset at beat 5, then a full restart from GSR fold 0 channel 0.
    send(1'b0, 12'h9C9);
    collect(1'b0, 1'b0, 4, 12'h9C9);
    check("mid_beat5_modality", 32'(dout_modality), 32'd1);
    dout_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_fin_ready", 32'(fin_ready), 32'd1);
    send(1'b0, 12'h9C9);
    collect(1'b0, 1'b0, 12, 12'h9C9);
    check("restart_end_valid", 32'(dout_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
